// File: rtl/sdr_cmd_sched.sv
// Command scheduler: arbitrates refresh (fixed priority) and host commands onto
// the single SDRAM command-generator path, with timeout, idle gap and late-refresh tracking.
module sdr_cmd_sched #(
  parameter int ASIZE   = 23,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255,
  parameter int RF_MAX  = 64
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             rf_req,
  output logic             rf_ack,
  input  logic             host_req,
  input  logic [2:0]       host_cmd,
  input  logic [ASIZE-1:0] host_addr,
  output logic             host_ack,
  output logic             issue_valid,
  output logic [2:0]       issue_cmd,
  output logic [ASIZE-1:0] issue_addr,
  input  logic             issue_done,
  output logic             busy,
  output logic             timeout,
  output logic             rf_late
);

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LD     = 8'(GAP);
  localparam logic [7:0] RF_LIMIT   = 8'(RF_MAX);
  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_REF    = 3'b011;

  state_t     state, state_nxt;
  logic [7:0] timer, gap_cnt, rf_wait, rf_wait_inc;
  logic       rf_grant, host_grant, expire;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rf_req || (host_req && host_cmd != CMD_NOP)) state_nxt = BUSY;
      BUSY:    if (issue_done || timer == TIMER_LAST)
                 state_nxt = (GAP_LD == '0) ? IDLE : RECOVER;
      RECOVER: if (gap_cnt <= 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    issue_valid = (state == BUSY);
    rf_grant    = (state == IDLE) && rf_req;
    // host_grant also covers a NOP: acked but never issued
    host_grant  = (state == IDLE) && !rf_req && host_req;
    expire      = (state == BUSY) && !issue_done && (timer == TIMER_LAST);
    rf_wait_inc = (rf_wait == 8'hFF) ? 8'hFF : rf_wait + 8'd1;
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      rf_ack     <= 1'b0;
      host_ack   <= 1'b0;
      timeout    <= 1'b0;
      issue_cmd  <= '0;
      issue_addr <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      rf_wait    <= '0;
      rf_late    <= 1'b0;
    end else begin
      rf_ack   <= rf_grant;
      host_ack <= host_grant;
      timeout  <= expire;

      if (rf_grant) begin
        issue_cmd  <= CMD_REF;
        issue_addr <= '0;
      end else if (host_grant && host_cmd != CMD_NOP) begin
        issue_cmd  <= host_cmd;
        issue_addr <= host_addr;
      end

      // Counters sit at their entry values outside their state, so entry needs no extra logic
      timer   <= (state == BUSY)    ? timer + 8'd1   : '0;
      gap_cnt <= (state == RECOVER) ? gap_cnt - 8'd1 : GAP_LD;

      if (!rf_req || rf_grant) begin
        rf_wait <= '0;
      end else begin
        rf_wait <= rf_wait_inc;
        if (rf_wait_inc >= RF_LIMIT) rf_late <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sdr_cmd_sched.md
# sdr_cmd_sched

Command scheduler for the SDRAM controller. It shares the single command path into the SDRAM command generator between two requesters: the refresh counter and the host command interface. It grants one command at a time, with refresh having fixed priority, and holds the command until the generator signals completion. It then enforces a programmable idle gap before the next grant. It produces per-requester one-cycle acknowledge pulses, a command-timeout flag and a sticky late-refresh flag.

## Interface
Parameters:
- ASIZE, 23: host address width.
- GAP, 2: idle cycles after each completed or aborted command, range 0–255.
- TIMEOUT, 255: maximum cycles to wait for `issue_done`, range 1–255.
- RF_MAX, 64: cycles a refresh may wait before `rf_late` is set, range 1–255.

Ports:
- clk0  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rf_req  in  1  refresh request level from the refresh counter; held until `rf_ack`.
- rf_ack  out  1  one-cycle pulse: refresh granted.
- host_req  in  1  host command request level; held until `host_ack`.
- host_cmd  in  3  host command: 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH, 100 PRECHARGE, 101 LOAD_MODE, 110 LOAD_REG1, 111 LOAD_REG2.
- host_addr  in  ASIZE  host address or register data.
- host_ack  out  1  one-cycle pulse: host command accepted.
- issue_valid  out  1  command presented to the command generator.
- issue_cmd  out  3  command code, same encoding as `host_cmd`.
- issue_addr  out  ASIZE  command address.
- issue_done  in  1  one-cycle completion pulse from the command generator.
- busy  out  1  high in any state other than IDLE.
- timeout  out  1  one-cycle pulse: command aborted for lack of `issue_done`.
- rf_late  out  1  sticky; refresh waited RF_MAX cycles; cleared only by reset.

## Operation
- States: IDLE, BUSY, RECOVER.
- **IDLE:**
  - If `rf_req` is high: latch `issue_cmd`=011 and `issue_addr`=0, pulse `rf_ack`, go to BUSY.
  - Otherwise, if `host_req` is high and `host_cmd`≠000: latch `host_cmd`/`host_addr`, pulse `host_ack`, go to BUSY.
  - Otherwise, if `host_req` is high and `host_cmd`=000: pulse `host_ack`, stay in IDLE, issue nothing.
- **BUSY:**
  - `issue_valid`=1 and `issue_cmd`/`issue_addr` are stable.
  - The timeout timer (8-bit) clears on entry and increments each BUSY edge.
  - `issue_done` sampled high → `issue_valid`=0, go to RECOVER.
  - Timer = TIMEOUT-1 with no `issue_done` → pulse `timeout`, `issue_valid`=0, go to RECOVER.
  - `issue_done` wins if it coincides with timer expiry: no `timeout` pulse.
- **RECOVER:**
  - The gap counter loads GAP on entry and decrements each cycle; return to IDLE when it reaches 0.
  - With GAP=0, go directly from BUSY to IDLE.
- Requests are not sampled in BUSY or RECOVER, and `issue_done` outside BUSY is ignored. A requester that drops its request the cycle after its ack therefore cannot be double-granted.
- **Refresh wait counter (8-bit, saturating):**
  - Increments each edge where `rf_req`=1 and no refresh grant occurs.
  - Clears when `rf_req`=0 or on a refresh grant.
  - Reaching RF_MAX sets `rf_late`, which holds until reset.
- **Reset** (async, any state, mid-command included): state=IDLE, all counters 0. Every output is 0: `rf_ack`, `host_ack`, `issue_valid`, `issue_cmd`, `issue_addr`, `busy`, `timeout`, `rf_late`.

## Timing
- Request sampled at edge N in IDLE → `issue_valid`, `issue_cmd`, `issue_addr`, `busy` and the ack are high after edge N. The ack is low again after edge N+1.
- Completion: `issue_done` may be accepted at any edge N+1 … N+TIMEOUT. If it is sampled at edge M, `issue_valid` goes low after M.
- Next grant:
  - After GAP cycles in RECOVER, IDLE is re-entered after edge M+GAP, and the earliest next grant is edge M+GAP+1.
  - With GAP=0, the earliest next grant is edge M+1.
- Timeout: no `issue_done` by edge N+TIMEOUT → `timeout` high for the cycle after edge N+TIMEOUT.
- NOP host request at edge N: `host_ack` is high after edge N; `busy` and `issue_valid` stay 0.
- `busy` = (state≠IDLE), registered.

## Test plan
- **Refresh grant:** reset released, `rf_req`=1 at edge 5 → `rf_ack` and `issue_valid` high after edge 5 with `issue_cmd`=011 and `issue_addr`=0; `issue_done` at edge 9 → `issue_valid` low after 9; next grant no earlier than edge 12 (GAP=2).
- **Priority:** `rf_req`=1 and `host_req`=1 (`host_cmd`=001, `host_addr`=0x1234) at the same edge → refresh is granted first; after its done plus gap, the host is granted with `issue_cmd`=001 and `issue_addr`=0x1234.
- **Timeout:** TIMEOUT=4, grant at edge 10, `issue_done` never asserted → `timeout` pulse after edge 14, then RECOVER; done at exactly edge 14 instead → no `timeout` pulse.
- **Late refresh:** RF_MAX=8, a host command holds BUSY for 20 cycles while `rf_req`=1 → `rf_late` rises after the 8th waiting edge and stays high after the refresh is granted.
- **Host NOP:** `host_req`=1 with `host_cmd`=000 → `host_ack` pulses once, `issue_valid` and `busy` stay 0.
- **Reset mid-command:** `reset` driven low in BUSY → all outputs 0 immediately, asynchronously; after release, a new request is granted normally.
